// File: rtl/vdp_regs_if.sv
// CPU bus between the Z80-side glue and the VDP register front end.
// The master drives port select, strobes and write data; the slave
// returns the registered read data.
interface vdp_regs_if;
    logic       cpu_port;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;

    modport master (
        output cpu_port,
        output cpu_wr,
        output cpu_rd,
        output cpu_din,
        input  cpu_dout
    );

    modport slave (
        input  cpu_port,
        input  cpu_wr,
        input  cpu_rd,
        input  cpu_din,
        output cpu_dout
    );
endinterface

// File: rtl/vdp_regs.sv
// CPU-side front end of a TMS9918-compatible VDP: port decode, registers
// R0-R7, auto-incrementing VRAM pointer with read-ahead buffer, status
// register fed by raster events, and the decoded controls for the raster.
module vdp_regs #(
    parameter int VRAM_AW = 14,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    vdp_regs_if.slave          cpu,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_wr,
    output logic               vram_rd,
    output logic [7:0]         vram_dout,
    input  logic [7:0]         vram_din,
    output logic [1:0]         mode,
    output logic               video_on,
    output logic               vert_retrace_int,
    output logic               sprite_large,
    output logic               sprite_enlarged,
    output logic [13:0]        name_table_addr,
    output logic [13:0]        color_table_addr,
    output logic [13:0]        font_addr,
    output logic [13:0]        sprite_attr_addr,
    output logic [13:0]        sprite_pattern_table_addr,
    output logic [3:0]         text_color,
    output logic [3:0]         back_color,
    input  logic               vblank,
    input  logic               sprite_collision,
    input  logic               too_many_sprites,
    input  logic [4:0]         sprite5,
    output logic               n_int
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } pf_state_t;

    pf_state_t          state;
    pf_state_t          state_next;
    logic [WAIT_W-1:0]  wait_cnt;

    logic [7:0]         regs [8];
    logic [VRAM_AW-1:0] pointer;
    logic [VRAM_AW-1:0] ptr_inc;
    logic [VRAM_AW-1:0] ptr_load;
    logic [7:0]         read_buf;
    logic [7:0]         latch_byte;
    logic               toggle;
    logic [7:0]         cpu_dout_q;

    logic               stat_f;
    logic               stat_5s;
    logic               stat_c;
    logic [4:0]         stat_field;
    logic               vblank_q;

    logic               pend_valid;
    logic               pend_port;
    logic               pend_wr;
    logic               pend_rd;
    logic [7:0]         pend_din;

    logic               live_strobe;
    logic               capture_live;
    logic               exec_valid;
    logic               exec_port;
    logic               exec_wr;
    logic               exec_rd;
    logic [7:0]         exec_din;

    logic               ctrl_wr;
    logic               data_wr;
    logic               data_rd;
    logic               stat_rd;
    logic               reg_wr;
    logic               ptr_set;
    logic               start_prefetch;
    logic               capture;
    logic               vblank_rise;

    logic               m1;
    logic               m2;
    logic               m3;
    logic               unused_reg_bits;

    // Choose the access to execute: a held strobe goes before a live one,
    // and nothing executes while a prefetch owns the VRAM port.
    always_comb begin
        live_strobe  = cpu.cpu_wr | cpu.cpu_rd;
        capture_live = live_strobe && ((state != S_IDLE) ? !pend_valid : pend_valid);
        exec_valid   = (state == S_IDLE) && (pend_valid || live_strobe);
        exec_port    = pend_valid ? pend_port : cpu.cpu_port;
        exec_wr      = pend_valid ? pend_wr   : cpu.cpu_wr;
        exec_rd      = pend_valid ? pend_rd   : cpu.cpu_rd;
        exec_din     = pend_valid ? pend_din  : cpu.cpu_din;

        ctrl_wr        = exec_valid &  exec_wr &  exec_port;
        data_wr        = exec_valid &  exec_wr & ~exec_port;
        data_rd        = exec_valid & ~exec_wr &  exec_rd & ~exec_port;
        stat_rd        = exec_valid & ~exec_wr &  exec_rd &  exec_port;
        reg_wr         = ctrl_wr &  toggle &  exec_din[7];
        ptr_set        = ctrl_wr &  toggle & ~exec_din[7];
        start_prefetch = data_rd | (ptr_set & ~exec_din[6]);

        ptr_inc  = pointer + VRAM_AW'(1);
        ptr_load = VRAM_AW'({exec_din[5:0], latch_byte});
        capture  = (state == S_WAIT) && (wait_cnt == '0);
        vblank_rise = vblank & ~vblank_q;
    end

    // Prefetch FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Prefetch FSM sequencing: one issue cycle, then RD_LAT wait cycles.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_prefetch) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wait_cnt == '0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Count down the VRAM read latency while waiting for read data.
    always_ff @(posedge clk) begin
        if (!reset)                                 wait_cnt <= '0;
        else if (state == S_ISSUE)                  wait_cnt <= WAIT_W'(RD_LAT - 1);
        else if (state == S_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
    end

    // One-deep slot holding a strobe that arrived while the port was busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_port  <= 1'b0;
            pend_wr    <= 1'b0;
            pend_rd    <= 1'b0;
            pend_din   <= 8'h00;
        end else begin
            if (capture_live) begin
                pend_valid <= 1'b1;
                pend_port  <= cpu.cpu_port;
                pend_wr    <= cpu.cpu_wr;
                pend_rd    <= cpu.cpu_rd;
                pend_din   <= cpu.cpu_din;
            end else if (state == S_IDLE) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Register file, pointer, read buffer, control toggle and CPU/VRAM data paths.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
            pointer    <= '0;
            read_buf   <= 8'h00;
            latch_byte <= 8'h00;
            toggle     <= 1'b0;
            cpu_dout_q <= 8'h00;
            vram_addr  <= '0;
            vram_dout  <= 8'h00;
            vram_wr    <= 1'b0;
        end else begin
            vram_wr <= data_wr;
            if (ctrl_wr) begin
                toggle <= ~toggle;
                if (!toggle) latch_byte <= exec_din;
            end
            if (data_wr | data_rd | stat_rd) toggle <= 1'b0;
            if (reg_wr) regs[exec_din[2:0]] <= latch_byte;
            if (ptr_set) begin
                pointer   <= ptr_load;
                vram_addr <= ptr_load;
            end
            if (data_wr) begin
                vram_addr <= pointer;
                vram_dout <= exec_din;
                read_buf  <= exec_din;
                pointer   <= ptr_inc;
            end
            if (data_rd) begin
                cpu_dout_q <= read_buf;
                pointer    <= ptr_inc;
                vram_addr  <= ptr_inc;
            end
            if (stat_rd) cpu_dout_q <= {stat_f, stat_5s, stat_c, stat_field};
            if (capture) read_buf <= vram_din;
        end
    end

    // Status flags: raster set events take priority over the read-clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_f     <= 1'b0;
            stat_5s    <= 1'b0;
            stat_c     <= 1'b0;
            stat_field <= 5'd0;
            vblank_q   <= 1'b0;
        end else begin
            vblank_q <= vblank;
            if (vblank_rise)           stat_f <= 1'b1;
            else if (stat_rd)          stat_f <= 1'b0;
            if (sprite_collision)      stat_c <= 1'b1;
            else if (stat_rd)          stat_c <= 1'b0;
            if (too_many_sprites)      stat_5s <= 1'b1;
            else if (stat_rd)          stat_5s <= 1'b0;
            if (!stat_5s)              stat_field <= sprite5;
        end
    end

    // Decoded mode, table bases, colours and interrupt for the raster block.
    always_comb begin
        m1 = regs[1][4];
        m2 = regs[1][3];
        m3 = regs[0][1];
        if (m1)      mode = 2'd0;
        else if (m2) mode = 2'd3;
        else if (m3) mode = 2'd2;
        else         mode = 2'd1;

        video_on         = regs[1][6];
        vert_retrace_int = regs[1][5];
        sprite_large     = regs[1][1];
        sprite_enlarged  = regs[1][0];

        name_table_addr           = {regs[2][3:0], 10'b0};
        sprite_attr_addr          = {regs[5][6:0], 7'b0};
        sprite_pattern_table_addr = {regs[6][2:0], 11'b0};
        if (mode == 2'd2) begin
            color_table_addr = {regs[3][7], 13'b0};
            font_addr        = {regs[4][2], 13'b0};
        end else begin
            color_table_addr = {regs[3], 6'b0};
            font_addr        = {regs[4][2:0], 11'b0};
        end

        text_color = regs[7][7:4];
        back_color = regs[7][3:0];
        n_int      = ~(stat_f & regs[1][5]);
        vram_rd    = (state == S_ISSUE);
        cpu.cpu_dout = cpu_dout_q;

        unused_reg_bits = ^{regs[0][7:2], regs[0][0], regs[1][7], regs[1][2],
                            regs[2][7:4], regs[4][7:3], regs[5][7], regs[6][7:3]};
    end

endmodule

// File: tb/tb_vdp_regs.sv
// Directed testbench for vdp_regs: drives CPU port accesses, models a
// one-cycle-latency VRAM, and checks outputs against hand-computed values.
module tb_vdp_regs;

    logic        clk;
    logic        reset;
    logic [13:0] vram_addr;
    logic        vram_wr;
    logic        vram_rd;
    logic [7:0]  vram_dout;
    logic [7:0]  vram_din;
    logic [1:0]  mode;
    logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
    logic [13:0] name_table_addr, color_table_addr, font_addr;
    logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
    logic [3:0]  text_color, back_color;
    logic        vblank, sprite_collision, too_many_sprites;
    logic [4:0]  sprite5;
    logic        n_int;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:16383];
    int          rd_count = 0;
    int          wr_count = 0;
    logic [13:0] last_rd_addr = '0;
    logic [13:0] last_wr_addr = '0;
    logic [7:0]  last_wr_data = '0;

    vdp_regs_if cpu_bus ();

    vdp_regs dut (
        .clk                       (clk),
        .reset                     (reset),
        .cpu                       (cpu_bus.slave),
        .vram_addr                 (vram_addr),
        .vram_wr                   (vram_wr),
        .vram_rd                   (vram_rd),
        .vram_dout                 (vram_dout),
        .vram_din                  (vram_din),
        .mode                      (mode),
        .video_on                  (video_on),
        .vert_retrace_int          (vert_retrace_int),
        .sprite_large              (sprite_large),
        .sprite_enlarged           (sprite_enlarged),
        .name_table_addr           (name_table_addr),
        .color_table_addr          (color_table_addr),
        .font_addr                 (font_addr),
        .sprite_attr_addr          (sprite_attr_addr),
        .sprite_pattern_table_addr (sprite_pattern_table_addr),
        .text_color                (text_color),
        .back_color                (back_color),
        .vblank                    (vblank),
        .sprite_collision          (sprite_collision),
        .too_many_sprites          (too_many_sprites),
        .sprite5                   (sprite5),
        .n_int                     (n_int)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VRAM model with one clock of read latency, plus access logging.
    always @(posedge clk) begin
        if (vram_rd) begin
            vram_din     <= mem[vram_addr];
            rd_count     <= rd_count + 1;
            last_rd_addr <= vram_addr;
        end
        if (vram_wr) begin
            mem[vram_addr] <= vram_dout;
            wr_count       <= wr_count + 1;
            last_wr_addr   <= vram_addr;
            last_wr_data   <= vram_dout;
        end
    end

    task automatic apply_write(input logic port, input logic [7:0] data);
        @(negedge clk);
        cpu_bus.cpu_port = port;
        cpu_bus.cpu_din  = data;
        cpu_bus.cpu_wr   = 1'b1;
        @(negedge clk);
        cpu_bus.cpu_wr   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_read(input logic port, output logic [7:0] data);
        @(negedge clk);
        cpu_bus.cpu_port = port;
        cpu_bus.cpu_rd   = 1'b1;
        @(negedge clk);
        cpu_bus.cpu_rd   = 1'b0;
        data = cpu_bus.cpu_dout;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cpu_bus.cpu_dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 00", cpu_bus.cpu_dout); end
        checks++; if (vram_wr !== 1'b0 || vram_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes: got wr=%b rd=%b expected 0 0", vram_wr, vram_rd); end
        checks++; if (n_int !== 1'b1) begin errors++; $display("[TB] FAIL reset_n_int: got %b expected 1", n_int); end
        checks++; if (mode !== 2'd1 || video_on !== 1'b0) begin errors++; $display("[TB] FAIL reset_mode: got mode=%0d video_on=%b expected 1 0", mode, video_on); end
        checks++; if (name_table_addr !== 14'h0 || font_addr !== 14'h0) begin errors++; $display("[TB] FAIL reset_bases: got name=%h font=%h expected 0 0", name_table_addr, font_addr); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_registers();
        apply_write(1'b1, 8'h02); apply_write(1'b1, 8'h80);
        checks++; if (mode !== 2'd2) begin errors++; $display("[TB] FAIL reg_mode2: got %0d expected 2", mode); end
        checks++; if (color_table_addr !== 14'h0 || font_addr !== 14'h0) begin errors++; $display("[TB] FAIL reg_mode2_bases: got color=%h font=%h expected 0 0", color_table_addr, font_addr); end
        apply_write(1'b1, 8'hFF); apply_write(1'b1, 8'h84);
        checks++; if (font_addr !== 14'h2000) begin errors++; $display("[TB] FAIL reg_font_mode2: got %h expected 2000", font_addr); end
        apply_write(1'b1, 8'hFF); apply_write(1'b1, 8'h83);
        checks++; if (color_table_addr !== 14'h2000) begin errors++; $display("[TB] FAIL reg_color_mode2: got %h expected 2000", color_table_addr); end
        apply_write(1'b1, 8'h0F); apply_write(1'b1, 8'h82);
        apply_write(1'b1, 8'hFF); apply_write(1'b1, 8'h85);
        apply_write(1'b1, 8'hFF); apply_write(1'b1, 8'h86);
        checks++; if (name_table_addr !== 14'h3C00) begin errors++; $display("[TB] FAIL reg_name: got %h expected 3c00", name_table_addr); end
        checks++; if (sprite_attr_addr !== 14'h3F80) begin errors++; $display("[TB] FAIL reg_sprite_attr: got %h expected 3f80", sprite_attr_addr); end
        checks++; if (sprite_pattern_table_addr !== 14'h3800) begin errors++; $display("[TB] FAIL reg_sprite_pat: got %h expected 3800", sprite_pattern_table_addr); end
        apply_write(1'b1, 8'h00); apply_write(1'b1, 8'h80);
        checks++; if (mode !== 2'd1 || color_table_addr !== 14'h3FC0 || font_addr !== 14'h3800) begin errors++; $display("[TB] FAIL reg_mode1_bases: got mode=%0d color=%h font=%h expected 1 3fc0 3800", mode, color_table_addr, font_addr); end
        apply_write(1'b1, 8'h63); apply_write(1'b1, 8'h81);
        checks++; if ({video_on, vert_retrace_int, sprite_large, sprite_enlarged} !== 4'b1111) begin errors++; $display("[TB] FAIL reg_r1_bits: got %b expected 1111", {video_on, vert_retrace_int, sprite_large, sprite_enlarged}); end
        apply_write(1'b1, 8'h18); apply_write(1'b1, 8'h81);
        checks++; if (mode !== 2'd0) begin errors++; $display("[TB] FAIL reg_mode0: got %0d expected 0", mode); end
        apply_write(1'b1, 8'h08); apply_write(1'b1, 8'h81);
        checks++; if (mode !== 2'd3) begin errors++; $display("[TB] FAIL reg_mode3: got %0d expected 3", mode); end
        apply_write(1'b1, 8'h00); apply_write(1'b1, 8'h81);
    endtask

    task automatic test_data_write();
        int rd0;
        rd0 = rd_count;
        apply_write(1'b1, 8'h00); apply_write(1'b1, 8'h41);
        apply_write(1'b0, 8'hAA);
        checks++; if (last_wr_addr !== 14'h0100 || last_wr_data !== 8'hAA) begin errors++; $display("[TB] FAIL dwr_first: got %h/%h expected 0100/aa", last_wr_addr, last_wr_data); end
        apply_write(1'b0, 8'hBB);
        checks++; if (last_wr_addr !== 14'h0101 || last_wr_data !== 8'hBB) begin errors++; $display("[TB] FAIL dwr_second: got %h/%h expected 0101/bb", last_wr_addr, last_wr_data); end
        apply_write(1'b0, 8'hCC);
        checks++; if (last_wr_addr !== 14'h0102) begin errors++; $display("[TB] FAIL dwr_pointer: got %h expected 0102", last_wr_addr); end
        checks++; if (rd_count !== rd0) begin errors++; $display("[TB] FAIL dwr_no_read: got %0d reads expected %0d", rd_count, rd0); end
    endtask

    task automatic test_prefetch_wrap();
        int rd0;
        logic [7:0] d;
        apply_write(1'b1, 8'hFF); apply_write(1'b1, 8'h7F);
        apply_write(1'b0, 8'h5A);
        apply_write(1'b0, 8'h11);
        checks++; if (last_wr_addr !== 14'h0000) begin errors++; $display("[TB] FAIL wrap_write: got %h expected 0000", last_wr_addr); end
        rd0 = rd_count;
        apply_write(1'b1, 8'hFF); apply_write(1'b1, 8'h3F);
        checks++; if (rd_count !== rd0 + 1 || last_rd_addr !== 14'h3FFF) begin errors++; $display("[TB] FAIL pf_setup: got %0d reads at %h expected %0d at 3fff", rd_count, last_rd_addr, rd0 + 1); end
        apply_read(1'b0, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("[TB] FAIL pf_read1: got %h expected 5a", d); end
        checks++; if (rd_count !== rd0 + 2 || last_rd_addr !== 14'h0000) begin errors++; $display("[TB] FAIL pf_wrap_read: got %0d reads at %h expected %0d at 0000", rd_count, last_rd_addr, rd0 + 2); end
        apply_read(1'b0, d);
        checks++; if (d !== 8'h11) begin errors++; $display("[TB] FAIL pf_read2: got %h expected 11", d); end
    endtask

    task automatic test_back_to_back();
        int rd0, wr0;
        logic [7:0] d;
        apply_write(1'b1, 8'h10); apply_write(1'b1, 8'h42);
        rd0 = rd_count;
        wr0 = wr_count;
        @(negedge clk);
        cpu_bus.cpu_port = 1'b0;
        cpu_bus.cpu_rd   = 1'b1;
        @(negedge clk);
        cpu_bus.cpu_rd   = 1'b0;
        cpu_bus.cpu_din  = 8'h77;
        cpu_bus.cpu_wr   = 1'b1;
        @(negedge clk);
        cpu_bus.cpu_wr   = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (rd_count !== rd0 + 1 || last_rd_addr !== 14'h0211) begin errors++; $display("[TB] FAIL b2b_read: got %0d reads at %h expected %0d at 0211", rd_count, last_rd_addr, rd0 + 1); end
        checks++; if (wr_count !== wr0 + 1 || last_wr_addr !== 14'h0211 || last_wr_data !== 8'h77) begin errors++; $display("[TB] FAIL b2b_pending_write: got %0d writes %h/%h expected %0d 0211/77", wr_count, last_wr_addr, last_wr_data, wr0 + 1); end
        apply_read(1'b0, d);
        checks++; if (d !== 8'h77) begin errors++; $display("[TB] FAIL b2b_buffer: got %h expected 77", d); end
    endtask

    task automatic test_status_int();
        logic [7:0] d;
        apply_write(1'b1, 8'h20); apply_write(1'b1, 8'h81);
        checks++; if (n_int !== 1'b1) begin errors++; $display("[TB] FAIL int_idle: got %b expected 1", n_int); end
        @(negedge clk); vblank = 1'b1;
        @(negedge clk);
        checks++; if (n_int !== 1'b0) begin errors++; $display("[TB] FAIL int_vblank: got %b expected 0", n_int); end
        apply_read(1'b1, d);
        checks++; if (d !== 8'h80) begin errors++; $display("[TB] FAIL int_status: got %h expected 80", d); end
        checks++; if (n_int !== 1'b1) begin errors++; $display("[TB] FAIL int_cleared: got %b expected 1", n_int); end
        vblank = 1'b0;
        repeat (2) @(negedge clk);
        cpu_bus.cpu_port = 1'b1;
        cpu_bus.cpu_rd   = 1'b1;
        vblank           = 1'b1;
        @(negedge clk);
        cpu_bus.cpu_rd   = 1'b0;
        checks++; if (cpu_bus.cpu_dout !== 8'h00) begin errors++; $display("[TB] FAIL int_coincide_dout: got %h expected 00", cpu_bus.cpu_dout); end
        checks++; if (n_int !== 1'b0) begin errors++; $display("[TB] FAIL int_coincide_set: got %b expected 0", n_int); end
        repeat (4) @(negedge clk);
        apply_read(1'b1, d);
        checks++; if (d !== 8'h80 || n_int !== 1'b1) begin errors++; $display("[TB] FAIL int_reread: got %h n_int=%b expected 80 1", d, n_int); end
        vblank = 1'b0;
    endtask

    task automatic test_toggle_clear();
        logic [7:0] d;
        apply_write(1'b1, 8'h12);
        apply_read(1'b0, d);
        apply_write(1'b1, 8'h07); apply_write(1'b1, 8'h87);
        checks++; if (back_color !== 4'd7 || text_color !== 4'd0) begin errors++; $display("[TB] FAIL toggle_r7: got back=%0d text=%0d expected 7 0", back_color, text_color); end
    endtask

    task automatic test_sprite_status();
        logic [7:0] d;
        @(negedge clk);
        too_many_sprites = 1'b1;
        sprite5          = 5'd9;
        @(negedge clk);
        too_many_sprites = 1'b0;
        sprite5          = 5'd0;
        repeat (2) @(negedge clk);
        apply_read(1'b1, d);
        checks++; if (d !== 8'h49) begin errors++; $display("[TB] FAIL sprite_5s: got %h expected 49", d); end
        apply_read(1'b1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL sprite_cleared: got %h expected 00", d); end
        @(negedge clk); sprite_collision = 1'b1;
        @(negedge clk); sprite_collision = 1'b0;
        apply_read(1'b1, d);
        checks++; if (d !== 8'h20) begin errors++; $display("[TB] FAIL sprite_coll: got %h expected 20", d); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        apply_write(1'b1, 8'h00);
        @(negedge clk);
        cpu_bus.cpu_port = 1'b1;
        cpu_bus.cpu_din  = 8'h00;
        cpu_bus.cpu_wr   = 1'b1;
        @(negedge clk);
        cpu_bus.cpu_wr   = 1'b0;
        checks++; if (vram_rd !== 1'b1 || vram_addr !== 14'h0000) begin errors++; $display("[TB] FAIL abort_issue: got rd=%b addr=%h expected 1 0000", vram_rd, vram_addr); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (vram_rd !== 1'b0 || vram_wr !== 1'b0) begin errors++; $display("[TB] FAIL abort_strobes: got rd=%b wr=%b expected 0 0", vram_rd, vram_wr); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (vram_rd !== 1'b0 || mode !== 2'd1) begin errors++; $display("[TB] FAIL abort_after: got rd=%b mode=%0d expected 0 1", vram_rd, mode); end
        apply_read(1'b0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL abort_buffer: got %h expected 00", d); end
    endtask

    // Test sequence.
    initial begin
        reset            = 1'b0;
        cpu_bus.cpu_port = 1'b0;
        cpu_bus.cpu_wr   = 1'b0;
        cpu_bus.cpu_rd   = 1'b0;
        cpu_bus.cpu_din  = 8'h00;
        vblank           = 1'b0;
        sprite_collision = 1'b0;
        too_many_sprites = 1'b0;
        sprite5          = 5'd0;

        test_reset();
        test_registers();
        test_data_write();
        test_prefetch_wrap();
        test_back_to_back();
        test_status_int();
        test_toggle_clear();
        test_sprite_status();
        test_reset_abort();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
